// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter/sequencer sharing one data_bus between
// instruction fetch (IF, read-only) and load/store (LS).
// The winning request is latched and driven on bus_* for WAIT_CYCLES cycles.
// bus_read/bus_exception are then sampled and returned to the winner with a
// one-cycle ack. All outputs are registered.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (word read), held until if_ack
//   if_ack/if_rdata/if_exc        fetch response, valid while if_ack=1
//   ls_req/ls_rw/ls_len/ls_addr/ls_wdata   load/store request, held until ls_ack
//   ls_ack/ls_rdata/ls_exc        load/store response, valid while ls_ack=1
//   bus_rw/bus_len/bus_addr/bus_write      registered request towards data_bus
//   bus_read/bus_exception        response from data_bus
//   busy                          high while a transaction is in ACCESS or RESP
module bus_arbiter #(
   parameter int unsigned WAIT_CYCLES  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   output logic        if_exc,
   input  logic        ls_req,
   input  logic        ls_rw,
   input  logic [1:0]  ls_len,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_ack,
   output logic [31:0] ls_rdata,
   output logic        ls_exc,
   output logic        bus_rw,
   output logic [1:0]  bus_len,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_write,
   input  logic [31:0] bus_read,
   input  logic        bus_exception,
   output logic        busy
);

   localparam int unsigned WAIT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [WAIT_W-1:0]   WAIT_LOAD  = WAIT_W'(WAIT_CYCLES - 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
   localparam logic [1:0]          IF_LEN     = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t              state;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [STARVE_W-1:0] starve_cnt;
   logic                grant_if;
   logic                grant_if_c;

   // IF wins when alone, or when LS has starved it for STARVE_LIMIT grants
   assign grant_if_c = if_req && (!ls_req || (starve_cnt == STARVE_MAX));

   // Arbitration, bus sequencing and response capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         starve_cnt <= '0;
         grant_if   <= 1'b0;
         if_ack     <= 1'b0;
         if_rdata   <= '0;
         if_exc     <= 1'b0;
         ls_ack     <= 1'b0;
         ls_rdata   <= '0;
         ls_exc     <= 1'b0;
         bus_rw     <= 1'b0;
         bus_len    <= '0;
         bus_addr   <= '0;
         bus_write  <= '0;
         busy       <= 1'b0;
      end else begin
         // acks are single-cycle pulses
         if_ack <= 1'b0;
         ls_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (if_req || ls_req) begin
                  state    <= ACCESS;
                  busy     <= 1'b1;
                  wait_cnt <= WAIT_LOAD;
                  grant_if <= grant_if_c;
                  if (grant_if_c) begin
                     bus_rw     <= 1'b0;
                     bus_len    <= IF_LEN;
                     bus_addr   <= if_addr;
                     bus_write  <= '0;
                     starve_cnt <= '0;
                  end else begin
                     bus_rw    <= ls_rw;
                     bus_len   <= ls_len;
                     bus_addr  <= ls_addr;
                     bus_write <= ls_rw ? ls_wdata : '0;
                     // count only LS grants that made a pending fetch wait
                     if (if_req) begin
                        if (starve_cnt != STARVE_MAX) begin
                           starve_cnt <= starve_cnt + STARVE_W'(1);
                        end
                     end else begin
                        starve_cnt <= '0;
                     end
                  end
               end
            end
            ACCESS: begin
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - WAIT_W'(1);
               end else begin
                  if (grant_if) begin
                     if_rdata <= bus_read;
                     if_exc   <= bus_exception;
                     if_ack   <= 1'b1;
                  end else begin
                     ls_rdata <= bus_read;
                     ls_exc   <= bus_exception;
                     ls_ack   <= 1'b1;
                  end
                  bus_rw    <= 1'b0;
                  bus_len   <= '0;
                  bus_addr  <= '0;
                  bus_write <= '0;
                  state     <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: self-checking bench for bus_arbiter.
// Main instance uses WAIT_CYCLES=3, STARVE_LIMIT=4; a second instance with
// WAIT_CYCLES=1 covers the shortest fetch latency. A data_bus stand-in
// returns resp_fn(bus_addr); acks are checked against a scoreboard queue.
module tb_bus_arbiter;

   localparam int unsigned WAIT   = 3;
   localparam int unsigned STARVE = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        if_exc;
   logic        ls_req;
   logic        ls_rw;
   logic [1:0]  ls_len;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_ack;
   logic [31:0] ls_rdata;
   logic        ls_exc;
   logic        bus_rw;
   logic [1:0]  bus_len;
   logic [31:0] bus_addr;
   logic [31:0] bus_write;
   logic [31:0] bus_read;
   logic        bus_exception;
   logic        busy;
   logic        exc_inj;

   logic        w_if_req;
   logic [31:0] w_if_addr;
   logic        w_if_ack;
   logic [31:0] w_if_rdata;
   logic        w_if_exc;
   logic        w_ls_ack;
   logic [31:0] w_ls_rdata;
   logic        w_ls_exc;
   logic        w_bus_rw;
   logic [1:0]  w_bus_len;
   logic [31:0] w_bus_addr;
   logic [31:0] w_bus_write;
   logic [31:0] w_bus_read;
   logic        w_busy;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] resp_fn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0000;
   endfunction

   assign bus_read      = resp_fn(bus_addr);
   assign bus_exception = exc_inj;
   assign w_bus_read    = resp_fn(w_bus_addr);

   bus_arbiter #(.WAIT_CYCLES(WAIT), .STARVE_LIMIT(STARVE)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_exc(if_exc),
      .ls_req(ls_req), .ls_rw(ls_rw), .ls_len(ls_len), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_exc(ls_exc),
      .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr), .bus_write(bus_write),
      .bus_read(bus_read), .bus_exception(bus_exception), .busy(busy)
   );

   bus_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(STARVE)) u_w1 (
      .clk(clk), .rst(rst),
      .if_req(w_if_req), .if_addr(w_if_addr), .if_ack(w_if_ack), .if_rdata(w_if_rdata), .if_exc(w_if_exc),
      .ls_req(1'b0), .ls_rw(1'b0), .ls_len(2'b00), .ls_addr(32'h0), .ls_wdata(32'h0),
      .ls_ack(w_ls_ack), .ls_rdata(w_ls_rdata), .ls_exc(w_ls_exc),
      .bus_rw(w_bus_rw), .bus_len(w_bus_len), .bus_addr(w_bus_addr), .bus_write(w_bus_write),
      .bus_read(w_bus_read), .bus_exception(1'b0), .busy(w_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   // Scoreboard: one entry per expected ack, in issue order
   typedef struct packed {
      logic        is_if;
      logic        chk_data;
      logic        exc;
      logic [31:0] rdata;
   } sb_t;

   sb_t sb[$];
   sb_t mon_e;

   always @(negedge clk) begin
      if (if_ack || ls_ack) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_ack", 32'(if_ack | ls_ack), 32'h0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_port", 32'(if_ack), 32'(mon_e.is_if));
            chk("sb_both_acks", 32'(if_ack & ls_ack), 32'h0);
            if (mon_e.chk_data)
               chk("sb_rdata", mon_e.is_if ? if_rdata : ls_rdata, mon_e.rdata);
            chk("sb_exc", 32'(mon_e.is_if ? if_exc : ls_exc), 32'(mon_e.exc));
         end
      end
   end

   task automatic push_exp(input logic is_if, input logic chk_data, input logic exc,
                           input logic [31:0] addr);
      sb_t e;
      e.is_if    = is_if;
      e.chk_data = chk_data;
      e.exc      = exc;
      e.rdata    = resp_fn(addr);
      sb.push_back(e);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_if_ack"},    32'(if_ack),    32'h0);
      chk({tag, "_if_rdata"},  if_rdata,       32'h0);
      chk({tag, "_if_exc"},    32'(if_exc),    32'h0);
      chk({tag, "_ls_ack"},    32'(ls_ack),    32'h0);
      chk({tag, "_ls_rdata"},  ls_rdata,       32'h0);
      chk({tag, "_ls_exc"},    32'(ls_exc),    32'h0);
      chk({tag, "_bus_rw"},    32'(bus_rw),    32'h0);
      chk({tag, "_bus_len"},   32'(bus_len),   32'h0);
      chk({tag, "_bus_addr"},  bus_addr,       32'h0);
      chk({tag, "_bus_write"}, bus_write,      32'h0);
      chk({tag, "_busy"},      32'(busy),      32'h0);
   endtask

   typedef struct {
      logic        is_if;
      logic        rw;
      logic [1:0]  len;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exc_inj;
      logic        mutate;
      logic        exp_rw;
      logic [1:0]  exp_len;
      logic [31:0] exp_addr;
      logic [31:0] exp_write;
   } vec_t;

   // One isolated transaction, entered and left at an IDLE-cycle negedge
   task automatic issue(input vec_t v, input int idx);
      string t;
      t = $sformatf("v%0d", idx);
      exc_inj = v.exc_inj;
      if (v.is_if) begin
         if_req  = 1'b1;
         if_addr = v.addr;
      end else begin
         ls_req   = 1'b1;
         ls_rw    = v.rw;
         ls_len   = v.len;
         ls_addr  = v.addr;
         ls_wdata = v.wdata;
      end
      push_exp(v.is_if, v.is_if || !v.rw, v.exc_inj, v.addr);
      for (int c = 0; c < int'(WAIT); c++) begin
         @(negedge clk);
         chk({t, "_bus_rw"},    32'(bus_rw),  32'(v.exp_rw));
         chk({t, "_bus_len"},   32'(bus_len), 32'(v.exp_len));
         chk({t, "_bus_addr"},  bus_addr,     v.exp_addr);
         chk({t, "_bus_write"}, bus_write,    v.exp_write);
         chk({t, "_busy"},      32'(busy),    32'h1);
         chk({t, "_early_ack"}, 32'(if_ack | ls_ack), 32'h0);
         if (v.mutate) begin
            if_addr  = ~v.addr;
            ls_addr  = ~v.addr;
            ls_wdata = ~v.wdata;
            ls_rw    = ~v.rw;
         end
      end
      @(negedge clk);
      chk({t, "_ack"},       32'(v.is_if ? if_ack : ls_ack), 32'h1);
      chk({t, "_bus_clr"},   bus_addr | bus_write | 32'(bus_rw) | 32'(bus_len), 32'h0);
      chk({t, "_busy_resp"}, 32'(busy), 32'h1);
      if_req  = 1'b0;
      ls_req  = 1'b0;
      exc_inj = 1'b0;
      @(negedge clk);
      chk({t, "_ack_clr"},   32'(if_ack | ls_ack), 32'h0);
      chk({t, "_busy_idle"}, 32'(busy), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        vecs [7];
      logic [9:0]  ord_exp;
      int          got;
      int          found;
      int          lat;

      // is_if rw len addr wdata exc mut | exp_rw exp_len exp_addr exp_write
      vecs[0] = '{1'b1, 1'b0, 2'b01, 32'h0000_0010, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0};
      vecs[1] = '{1'b0, 1'b1, 2'b10, 32'h1000_0004, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 2'b10, 32'h1000_0004, 32'hDEAD_BEEF};
      vecs[2] = '{1'b0, 1'b0, 2'b01, 32'h2000_0008, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 2'b01, 32'h2000_0008, 32'h0};
      vecs[3] = '{1'b0, 1'b1, 2'b11, 32'hFFFF_FFFC, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 2'b11, 32'hFFFF_FFFC, 32'h0000_0001};
      vecs[4] = '{1'b0, 1'b0, 2'b00, 32'h0000_0030, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0030, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 2'b00, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'h0};
      vecs[6] = '{1'b0, 1'b0, 2'b10, 32'h0000_0050, 32'h0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_0050, 32'h0};

      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_rw = 1'b0; ls_len = '0; ls_addr = '0; ls_wdata = '0;
      exc_inj = 1'b0;
      w_if_req = 1'b0; w_if_addr = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      chk("reset_w1_busy", 32'(w_busy) | w_bus_addr | w_if_rdata, 32'h0);
      rst = 1'b0;

      // WAIT_CYCLES=1 fetch: one bus cycle, ack two cycles after request
      w_if_req  = 1'b1;
      w_if_addr = 32'h0000_0010;
      @(negedge clk);
      chk("t1_bus_addr", w_bus_addr, 32'h0000_0010);
      chk("t1_bus_rw",   32'(w_bus_rw),  32'h0);
      chk("t1_bus_len",  32'(w_bus_len), 32'h2);
      chk("t1_no_ack",   32'(w_if_ack),  32'h0);
      @(negedge clk);
      chk("t1_if_ack",   32'(w_if_ack),  32'h1);
      chk("t1_if_rdata", w_if_rdata, resp_fn(32'h0000_0010));
      chk("t1_bus_clr",  w_bus_addr, 32'h0);
      chk("t1_ls_ack",   32'(w_ls_ack),  32'h0);
      w_if_req = 1'b0;
      @(negedge clk);
      chk("t1_ack_clr",  32'(w_if_ack),  32'h0);
      chk("t1_busy",     32'(w_busy),    32'h0);

      // Table-driven single transactions on the WAIT_CYCLES=3 instance
      for (int i = 0; i < 7; i++) issue(vecs[i], i);
      // fetch exception and data held across a later LS ack
      chk("t4_if_exc_hold",   32'(if_exc), 32'h1);
      chk("t4_if_rdata_hold", if_rdata, resp_fn(32'h0000_0040));

      // Both masters requesting continuously: IF forced every fifth grant
      ord_exp = 10'b10_0001_0000;
      for (int g = 0; g < 10; g++)
         push_exp(ord_exp[g], 1'b1, 1'b0, ord_exp[g] ? 32'h0000_0100 : 32'h0000_0200);
      if_addr = 32'h0000_0100;
      ls_addr = 32'h0000_0200;
      ls_rw = 1'b0; ls_len = 2'b10; ls_wdata = '0;
      if_req = 1'b1; ls_req = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
         @(negedge clk);
         if (if_ack || ls_ack) begin
            chk($sformatf("t3_grant_%0d", got), 32'(if_ack), 32'(ord_exp[got]));
            got++;
            if (if_ack) if_req = 1'b0;
            else        ls_req = 1'b0;
         end else begin
            if_req = 1'b1;
            ls_req = 1'b1;
         end
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      chk("t3_grant_count", 32'(got), 32'd10);
      @(negedge clk);

      // Reset during an LS access aborts it; the pending fetch goes next
      if_addr = 32'h0000_0300; if_req = 1'b1;
      ls_req = 1'b1; ls_rw = 1'b1; ls_len = 2'b10;
      ls_addr = 32'h0000_0400; ls_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      chk("t5_ls_won", bus_addr, 32'h0000_0400);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("t5_rst");
      rst = 1'b0;
      ls_req = 1'b0;
      push_exp(1'b1, 1'b1, 1'b0, 32'h0000_0300);
      found = 0;
      lat = 0;
      for (int cyc = 1; cyc <= 20 && found == 0; cyc++) begin
         @(negedge clk);
         if (ls_ack) chk("t5_no_ls_ack", 32'(ls_ack), 32'h0);
         if (if_ack) begin
            found = 1;
            lat = cyc;
            if_req = 1'b0;
         end
      end
      chk("t5_if_served", 32'(found), 32'h1);
      chk("t5_if_latency", 32'(lat), 32'(WAIT + 1));
      repeat (2) @(negedge clk);

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
